// File: rtl/sqrt_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_arbiter_if
// Purpose  : Bundles the requester, core and response streams of the shared
//            square-root arbiter. The slave view belongs to the arbiter; the
//            master view belongs to whatever surrounds it.
// Revision : 1.0 - initial release
// ============================================================================
interface sqrt_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) ();

  // Requester side
  logic [NUM_REQ-1:0]            req_tvalid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata;
  logic [NUM_REQ-1:0]            req_tready;

  // Toward the shared core
  logic                          core_in_tvalid;
  logic [DATA_WIDTH-1:0]         core_in_tdata;
  logic                          core_in_tready;

  // From the shared core (cannot be stalled)
  logic                          core_out_tvalid;
  logic [DATA_WIDTH-1:0]         core_out_tdata;

  // Results back to the requesters, plus status
  logic [NUM_REQ-1:0]            rsp_tvalid;
  logic [DATA_WIDTH-1:0]         rsp_tdata;
  logic                          busy;
  logic                          unexpected_rsp;

  modport slave (
    input  req_tvalid, req_tdata, core_in_tready, core_out_tvalid, core_out_tdata,
    output req_tready, core_in_tvalid, core_in_tdata, rsp_tvalid, rsp_tdata,
           busy, unexpected_rsp
  );

  modport master (
    output req_tvalid, req_tdata, core_in_tready, core_out_tvalid, core_out_tdata,
    input  req_tready, core_in_tvalid, core_in_tdata, rsp_tvalid, rsp_tdata,
           busy, unexpected_rsp
  );

endinterface
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_arbiter
// Purpose  : Round-robin arbiter sharing one non-stallable square-root core
//            among NUM_REQ requesters. A one-entry issue stage feeds the core;
//            an in-order tag FIFO routes each result back to its owner.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 8    // power of two, at least 2
) (
  input  logic         s00_axis_aclk,
  input  logic         s00_axis_aresetn,
  sqrt_arbiter_if.slave bus
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] c_LAST_REQ = TAG_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(TAG_DEPTH);

  // Round-robin pointer and issue stage
  logic [TAG_W-1:0]      r_rr_ptr;
  logic                  r_stage_valid;
  logic [DATA_WIDTH-1:0] r_stage_data;
  logic [TAG_W-1:0]      r_stage_tag;

  // In-order tag FIFO
  logic [TAG_W-1:0]      r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  // Response register and sticky error
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_unexpected;

  logic                  w_hi_any, w_lo_any, w_grant_any;
  logic [TAG_W-1:0]      w_hi_idx, w_lo_idx, w_grant_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [CNT_W-1:0]      w_occ;
  logic                  w_slot_free;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [NUM_REQ-1:0]    w_head_onehot;

  // Occupancy counts the staged entry so the FIFO can never overflow
  assign w_occ       = r_count + {{(CNT_W-1){1'b0}}, r_stage_valid};
  assign w_slot_free = (!r_stage_valid || bus.core_in_tready) && (w_occ < c_DEPTH);
  assign w_accept    = s00_axis_aresetn && w_slot_free && w_grant_any;
  assign w_push      = r_stage_valid && bus.core_in_tready;
  assign w_pop       = bus.core_out_tvalid && (r_count != '0);

  // Round-robin search: first valid at or above the pointer, else first valid below it
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hi_any && bus.req_tvalid[i] && (TAG_W'(i) >= r_rr_ptr)) begin
        w_hi_any = 1'b1;
        w_hi_idx = TAG_W'(i);
      end
      if (!w_lo_any && bus.req_tvalid[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = TAG_W'(i);
      end
    end
    w_grant_any = w_hi_any || w_lo_any;
    w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
  end

  // Ready strobe, granted data slice and one-hot decode of the FIFO head tag
  always_comb begin
    bus.req_tready = '0;
    w_sel_data     = '0;
    w_head_onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_tready[i] = w_accept && (w_grant_idx == TAG_W'(i));
      if (w_grant_idx == TAG_W'(i)) begin
        w_sel_data = bus.req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      w_head_onehot[i] = (r_tag_mem[r_rptr] == TAG_W'(i));
    end
  end

  // Issue stage and round-robin pointer advance on every accepted request
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_rr_ptr      <= '0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_stage_tag   <= '0;
    end else if (w_accept) begin
      r_rr_ptr      <= (w_grant_idx == c_LAST_REQ) ? '0 : w_grant_idx + TAG_W'(1);
      r_stage_valid <= 1'b1;
      r_stage_data  <= w_sel_data;
      r_stage_tag   <= w_grant_idx;
    end else if (w_push) begin
      r_stage_valid <= 1'b0;
    end
  end

  // Tag storage; contents are only meaningful between the pointers
  always_ff @(posedge s00_axis_aclk) begin
    if (w_push) begin
      r_tag_mem[r_wptr] <= r_stage_tag;
    end
  end

  // FIFO pointers wrap naturally; simultaneous push and pop keep the count
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle response pulse to the head-tag owner; stray results latch the error flag
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_unexpected <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rsp_valid <= w_head_onehot;
        r_rsp_data  <= bus.core_out_tdata;
      end else begin
        r_rsp_valid <= '0;
      end
      if (bus.core_out_tvalid && (r_count == '0)) begin
        r_unexpected <= 1'b1;
      end
    end
  end

  assign bus.core_in_tvalid = r_stage_valid;
  assign bus.core_in_tdata  = r_stage_data;
  assign bus.rsp_tvalid     = r_rsp_valid;
  assign bus.rsp_tdata      = r_rsp_data;
  assign bus.busy           = r_stage_valid || (r_count != '0);
  assign bus.unexpected_rsp = r_unexpected;

endmodule
`default_nettype wire

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the square-root core.
REQ-002 Parameter DATA_WIDTH, default 32: width of the radicand and of the result word.
REQ-003 Parameter TAG_DEPTH, default 8 (power of 2): maximum number of requests outstanding in the core.
REQ-004 Port s00_axis_aclk  in  1: sole clock; all logic rises on its positive edge.
REQ-005 Port s00_axis_aresetn  in  1: asynchronous, active-low reset.
REQ-006 Port req_tvalid  in  NUM_REQ: per-requester radicand valid.
REQ-007 Port req_tdata  in  NUM_REQ*DATA_WIDTH: radicands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_tready  out  NUM_REQ: per-requester accept; at most one bit is high per cycle.
REQ-009 Port core_in_tvalid  out  1: radicand valid toward the shared CORDIC square-root core.
REQ-010 Port core_in_tdata  out  DATA_WIDTH: radicand to the core.
REQ-011 Port core_in_tready  in  1: core accepts the radicand.
REQ-012 Port core_out_tvalid  in  1: core result valid, single-cycle pulse; the core cannot be stalled.
REQ-013 Port core_out_tdata  in  DATA_WIDTH: core result.
REQ-014 Port rsp_tvalid  out  NUM_REQ: one-hot result strobe identifying the owning requester.
REQ-015 Port rsp_tdata  out  DATA_WIDTH: result word, shared by all requesters.
REQ-016 Port busy  out  1: high while the issue stage or the tag FIFO is non-empty.
REQ-017 Port unexpected_rsp  out  1: sticky flag, set when core_out_tvalid arrives while the tag FIFO is empty.

Function
REQ-018 The block SHALL hold a one-entry issue stage (data, tag) driving core_in_tdata/core_in_tvalid; the stage holds its contents until core_in_tvalid && core_in_tready.
REQ-019 The block SHALL compute slot_free = (!stage_valid || core_in_tready) && (fifo_count + stage_valid < TAG_DEPTH).
REQ-020 Round-robin arbitration: search starts at pointer rr_ptr and moves upward modulo NUM_REQ; req_tready[i] = slot_free && i is the first index found with req_tvalid set; req_tready is combinational from req_tvalid and state.
REQ-021 On a req handshake from index i, the block SHALL load the stage with req_tdata slice i and tag i, and SHALL set rr_ptr to (i+1) mod NUM_REQ on the same edge; with no handshake rr_ptr holds.
REQ-022 Issue latency: a request accepted on edge N SHALL present core_in_tvalid=1 in the cycle after edge N; back-to-back acceptance SHALL be supported when core_in_tready stays high (one request per cycle).
REQ-023 The tag of the stage SHALL be pushed into an in-order tag FIFO (depth TAG_DEPTH, width clog2(NUM_REQ) minimum 1) on each core handshake.
REQ-024 On core_out_tvalid with the FIFO non-empty, the block SHALL pop the head tag and, on the next edge, drive rsp_tdata=core_out_tdata and rsp_tvalid=one-hot(tag) for exactly one cycle.
REQ-025 A push and a pop on the same edge SHALL leave fifo_count unchanged; read/write pointers wrap modulo TAG_DEPTH.
REQ-026 On core_out_tvalid with the FIFO empty, the block SHALL drop the result, keep rsp_tvalid at 0, and set unexpected_rsp to 1 until reset.
REQ-027 With fifo_count + stage_valid = TAG_DEPTH, all req_tready bits SHALL be 0; acceptance SHALL resume in the cycle after the next pop.
REQ-028 Requesters SHALL receive results in the order their requests entered the core; rsp_tvalid pulses SHALL require no back-pressure.
REQ-029 The module SHALL NOT modify data: core_in_tdata equals the accepted slice bit-exactly, and rsp_tdata equals core_out_tdata bit-exactly.

Reset
REQ-030 While s00_axis_aresetn=0, without waiting for a clock edge, the block SHALL clear core_in_tvalid, core_in_tdata, rsp_tvalid, rsp_tdata, busy, unexpected_rsp, rr_ptr, the stage and the FIFO pointers and count to 0.
REQ-031 Reset mid-operation SHALL discard outstanding tags; core results that arrive after reset release SHALL be handled per REQ-026.
REQ-032 req_tready SHALL be 0 during reset and SHALL be valid from the first edge after release.

Verification
REQ-033 Single request: req_tvalid=01, req_tdata[31:0]=0x00000019, core returns 0x5 -> core_in_tdata=0x19 one cycle after accept; rsp_tvalid=01 and rsp_tdata=0x5 one cycle after core_out_tvalid.
REQ-034 Contention: both requesters valid continuously, core_in_tready=1 -> grants alternate 0,1,0,1; rsp_tvalid follows 01,10,01,10 in issue order.
REQ-035 Full: TAG_DEPTH=8, core_in_tready=1, no core output -> exactly 8 handshakes then req_tready=0; one core_out_tvalid -> one further accept on the following cycle.
REQ-036 Stall: core_in_tready=0 for 5 cycles with stage loaded -> core_in_tdata stable, req_tready=0, no FIFO push; accept resumes when core_in_tready=1.
REQ-037 Simultaneous push and pop with fifo_count=3 -> count stays 3; pointer wrap exercised over 20 transactions with no loss or misrouting.
REQ-038 Stray result: core_out_tvalid with an empty FIFO -> unexpected_rsp=1 sticky, rsp_tvalid=00; async reset mid-burst -> all outputs 0 immediately.
